// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment scanner: double-buffered hex value, blank gap
// between digits, leading-zero ripple blanking, frame-aligned buffer update.
module sevenseg_scanner #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 3000,
  parameter int BLANK_CYCLES = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  lz_en,
  output logic                  update_ack,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_tick
);

  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(DIGITS);

  typedef enum logic {ST_BLANK, ST_DISPLAY} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  update_ack_q, update_ack_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [3:0]            nib;
  logic                  rb_blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0111111;  4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;  4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;  4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;  4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;  4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;  default: hex7 = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    seg_d        = seg_q;
    seg_dp_d     = seg_dp_q;
    digit_en_d   = digit_en_q;
    update_ack_d = 1'b0;
    frame_tick_d = 1'b0;
    nib          = '0;
    rb_blank     = 1'b0;

    if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_DISPLAY;
          cnt_d   = '0;
          if (idx_q == '0) begin
            frame_tick_d = 1'b1;
            // Old pending value transfers; a simultaneous load stays pending.
            if (pend_flag_q) begin
              disp_data_d  = pend_data_q;
              disp_dp_d    = pend_dp_q;
              update_ack_d = 1'b1;
              if (!load) pend_flag_d = 1'b0;
            end
          end
          nib        = disp_data_d[{idx_q, 2'b00} +: 4];
          rb_blank   = lz_en && (idx_q != '0) && ((disp_data_d >> {idx_q, 2'b00}) == '0);
          digit_en_d = DIGITS'(1) << idx_q;
          seg_d      = rb_blank ? 7'b0000000 : hex7(nib);
          seg_dp_d   = disp_dp_d[idx_q];
        end
      end
      default: begin
        if (cnt_q == CW'(PRESCALE - 1)) begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
          digit_en_d = '0;
          seg_d      = '0;
          seg_dp_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      seg_q        <= '0;
      seg_dp_q     <= 1'b0;
      digit_en_q   <= '0;
      update_ack_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      digit_en_q   <= digit_en_d;
      update_ack_q <= update_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign digit_en   = digit_en_q;
  assign update_ack = update_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench for sevenseg_scanner: a frame-level model predicts each digit
// phase entry; a monitor pops and compares whenever a digit is driven.
module tb_sevenseg_scanner;
  localparam int D = 4, P = 4, B = 2;
  localparam int PER = P + B;
  localparam int FRAME = D * PER;

  logic clk = 1'b0;
  logic rst_n;
  logic [4*D-1:0] data;
  logic [D-1:0] dp;
  logic load, lz_en;
  logic update_ack, seg_dp, frame_tick;
  logic [6:0] seg;
  logic [D-1:0] digit_en;

  sevenseg_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .load(load), .lz_en(lz_en),
    .update_ack(update_ack), .seg(seg), .seg_dp(seg_dp), .digit_en(digit_en),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    logic [D-1:0] en;
    logic [6:0] seg;
    logic dp;
    logic ack;
    logic tick;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int errors = 0, checks = 0;
  int k = 0;
  logic [6:0] hex_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  logic [4*D-1:0] m_disp, m_pdata;
  logic [D-1:0] m_dpb, m_pdp;
  logic m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, req);
    end
  endtask

  // Reference model: digit phases begin at cycle counts B+n*PER after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_disp = '0; m_dpb = '0; m_pdata = '0; m_pdp = '0; m_pend = 1'b0;
      exp_q.delete();
    end else begin
      exp_t e;
      int d;
      logic blank;
      k++;
      if (k % PER == B) begin
        d = (k / PER) % D;
        e.ack = 1'b0;
        if (d == 0 && m_pend) begin
          m_disp = m_pdata; m_dpb = m_pdp; m_pend = 1'b0; e.ack = 1'b1;
        end
        blank  = lz_en && d != 0 && (m_disp >> (4 * d)) == 0;
        e.k    = k;
        e.en   = D'(1) << d;
        e.seg  = blank ? 7'd0 : hex_tab[m_disp[4*d +: 4]];
        e.dp   = m_dpb[d];
        e.tick = (d == 0);
        exp_q.push_back(e);
      end
      if (load) begin
        m_pdata = data; m_pdp = dp; m_pend = 1'b1;
      end
    end
  end

  // Monitor
  logic [D-1:0] prev_en;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = '0;
    end else begin
      check("scan_phase", 32'(digit_en != 0), 32'((k % PER) >= B));
      if (digit_en == 0) begin
        check("blank_out", {seg_dp, seg, update_ack, frame_tick}, 0);
      end else if (prev_en == 0) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("entry_time", 32'(k), 32'(cur.k));
          check("digit_en", 32'(digit_en), 32'(cur.en));
          check("seg", 32'(seg), 32'(cur.seg));
          check("seg_dp", 32'(seg_dp), 32'(cur.dp));
          check("update_ack", 32'(update_ack), 32'(cur.ack));
          check("frame_tick", 32'(frame_tick), 32'(cur.tick));
        end
      end else begin
        check("hold", {digit_en, seg_dp, seg, update_ack, frame_tick},
              {cur.en, cur.dp, cur.seg, 1'b0, 1'b0});
      end
      prev_en = digit_en;
    end
  end

  task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] p);
    data = v; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_k(input int r);
    bit found = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (k % FRAME == r) begin found = 1; break; end
    end
    check("wait_k_timeout", 32'(found), 1);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data = '0; dp = '0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {seg, seg_dp, digit_en, update_ack, frame_tick}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    wait_k(13);
    do_load(16'h12AF, 4'b0100);
    repeat (2 * FRAME) @(negedge clk);

    lz_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    repeat (2 * FRAME) @(negedge clk);
    do_load(16'h0000, 4'b0000);
    repeat (2 * FRAME) @(negedge clk);
    lz_en = 1'b0;

    wait_k(5);
    do_load(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    repeat (2 * FRAME) @(negedge clk);

    do_load(16'h3333, 4'b0000);
    wait_k(1);
    do_load(16'h4444, 4'b1000);
    repeat (3 * FRAME) @(negedge clk);

    // Asynchronous reset while digit 2 is driven.
    do_load(16'hBEEF, 4'b1111);
    repeat (FRAME) @(negedge clk);
    wait_k(15);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {seg, seg_dp, digit_en, update_ack, frame_tick}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      lz_en = 1'($urandom);
      do_load((4*D)'($urandom), D'($urandom));
    end
    repeat (2 * FRAME) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sevenseg_scanner.md
Name: sevenseg_scanner

Overview:
- Time-multiplexed controller for a DIGITS-wide common-cathode seven-segment display sharing one segment bus.
- Holds a double-buffered hex value and scans one digit at a time, with a blanking gap between digits to prevent ghosting.
- Decodes hex digits internally, including ripple blanking of leading zeros and per-digit decimal points.
- Sits between a register/CPU-side producer (load/ack) and the board display pins.

Parameters:
- DIGITS, 4, number of digits (2..8)
- PRESCALE, 3000, clk cycles a digit is driven (>=1)
- BLANK_CYCLES, 30, clk cycles all digits are off between digits (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i], digit 0 least significant
- dp  in  DIGITS  decimal point per digit
- load  in  1  one-cycle strobe; captures data/dp into the pending buffer
- lz_en  in  1  leading-zero suppression enable (level, sampled live)
- update_ack  out  1  one-cycle pulse when the pending value is transferred to the display buffer
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- seg_dp  out  1  decimal point segment, active-high
- digit_en  out  DIGITS  one-hot digit select, active-high; all zero in the blank phase
- frame_tick  out  1  one-cycle pulse at the start of every digit-0 display phase

Behaviour:
- Reset (async assert, sync release): seg=0, seg_dp=0, digit_en=0, update_ack=0, frame_tick=0; display buffer, pending buffer and pending flag = 0; idx=0; FSM=BLANK with counter=0.
- FSM has two states:
  - BLANK: lasts BLANK_CYCLES cycles; digit_en=0, seg=0, seg_dp=0.
  - DISPLAY: lasts PRESCALE cycles; digit_en[idx]=1, and seg/seg_dp show the decode of display nibble idx.
- Transitions:
  - BLANK -> DISPLAY (same idx) when counter = BLANK_CYCLES-1.
  - DISPLAY -> BLANK when counter = PRESCALE-1; idx advances, wrapping DIGITS-1 -> 0.
  - Counter clears on every transition.
- Digit period = PRESCALE+BLANK_CYCLES; frame = DIGITS*(PRESCALE+BLANK_CYCLES).
- All outputs are registered: they change in the cycle the FSM state changes. No combinational path from inputs to outputs.
- Frame boundary = the BLANK->DISPLAY transition with idx=0, including the first one after reset. At that edge:
  - If pending flag=1: display buffer <= pending buffer, pending flag <= 0, update_ack=1 for that cycle.
  - Otherwise no update and no ack.
  - frame_tick=1 on the same cycle as the first digit-0 DISPLAY output.
- load:
  - Captures data/dp into the pending buffer and sets the pending flag.
  - Repeated loads before a frame boundary overwrite; last wins, with one ack.
  - load in the same cycle as a frame transfer: the old pending value transfers and acks; the new data enters pending and the flag stays 1, so it is shown at the next frame.
- The display buffer changes only at frame boundaries, so no tearing within a frame.
- Hex decode ({g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Ripple blanking:
  - Digit i (i>=1) is blanked when lz_en=1 and display nibbles i..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=0 but still drives its dp bit and still asserts its digit_en. Scan timing is unchanged.
- lz_en and dp are evaluated from the display buffer and live lz_en at each DISPLAY entry; changes mid-phase take effect at the next digit.
- Reset mid-frame: outputs go to 0 immediately and buffers clear. The first frame after release shows 0 (or blank leading zeros per lz_en).

Test Plan (DIGITS=4, PRESCALE=4, BLANK_CYCLES=2):
- Reset release, no load -> digit_en=0 for 2 cycles, then 0001 for 4 cycles with seg=0111111; sequence 0001,0010,0100,1000 every 6 cycles; frame_tick every 24 cycles; update_ack never fires.
- load data=16'h12AF, dp=4'b0100 mid-frame -> no change until next frame_tick, update_ack coincident with it; digits show F=1110001, A=1110111, 2=1011011 with seg_dp=1, 1=0000110.
- lz_en=1, load 16'h0050 -> digits 3 and 2 seg=0 (digit_en still pulses), digit1=1101101, digit0=0111111; load 16'h0000 -> only digit 0 shows 0111111.
- Two loads (16'h1111, then 16'h2222) within one frame -> single update_ack; display shows 2222.
- load asserted exactly on a frame-transfer cycle with 16'h3333 pending and 16'h4444 on data -> 3333 shown with ack; 4444 shown one frame later with a second ack.
- Assert rst_n=0 during DISPLAY of digit 2 -> seg, digit_en and update_ack are 0 asynchronously; after release the scan restarts at BLANK, digit 0, value 0.
